uart8250_ctrl: RTL
==================

Name: uart8250_ctrl

Overview:
- Front-end controller for the 8250 register port (read: rvalid/raddr/rdata; write: wvalid/waddr/wdata).
- After reset, runs a fixed init sequence that programs divisor, line format, FIFO and interrupt-enable registers.
- Then shares the transmitter among NREQ character producers with round-robin arbitration. Each accepted character is written to THR, optionally gated by LSR.THRE polling.

Parameters:
- NREQ, 2, number of character requesters (1..8).
- DIVISOR, 16'h0001, baud divisor written to DLL/DLM.
- LCR_CFG, 8'h03, line format (8N1); bit 7 is always forced to 0 in the final LCR write.
- FCR_CFG, 8'h07, value written to FCR.
- POLL_LSR, 0, 1 = poll LSR bit 5 (THRE) before each THR write.
- POLL_TIMEOUT, 255, maximum LSR polls per character; 0 = unlimited.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- req_valid  in  NREQ  per-requester character valid
- req_data  in  8*NREQ  per-requester character; requester i uses bits [8i+7:8i]
- req_ready  out  NREQ  one-cycle accept pulse, one-hot
- init_done  out  1  high once the init sequence has completed
- busy  out  1  high in any state other than IDLE
- tx_err  out  1  sticky; set when a poll timeout drops a character
- tx_count  out  16  number of THR writes issued; wraps at 16'hFFFF
- u_rvalid  out  1  UART read strobe
- u_raddr  out  3  UART read address
- u_rdata  in  8  UART read data; valid in the cycle after u_rvalid
- u_wvalid  out  1  UART write strobe
- u_waddr  out  3  UART write address
- u_wdata  out  8  UART write data

Behaviour:
- Reset (rstn=0 at a clk edge): all outputs 0; FSM in I_LCRD; RR pointer 0; capture register cleared; tx_err=0; tx_count=0.
- Reset asserted at any point aborts the current operation. Any captured character is discarded, and the init sequence reruns from the start.
- Init sequence: one write per cycle, u_wvalid=1, in this order:
  - I_LCRD: addr 3, data 8'h80|LCR_CFG
  - I_DLL: addr 0, data DIVISOR[7:0]
  - I_DLM: addr 1, data DIVISOR[15:8]
  - I_LCR: addr 3, data LCR_CFG & 8'h7F
  - I_FCR: addr 2, data FCR_CFG
  - I_IER: addr 1, data 8'h00
  - then IDLE.
- Timing: first write occurs in the first cycle after reset release. init_done rises in cycle 7 and stays high until the next reset.
- req_valid is ignored (req_ready=0) while init_done=0.
- IDLE arbitration:
  - If any req_valid is high, grant the first requester at or after the RR pointer, wrapping modulo NREQ.
  - In that cycle, pulse req_ready[g], capture req_data[g], and set pointer = (g+1) mod NREQ.
  - Next state: SEND if POLL_LSR=0, else P_RD.
- Requester rules: hold req_valid and data stable until req_ready; the transfer completes on the req_ready cycle.
- P_RD: u_rvalid=1, u_raddr=5; clear the poll counter on entry from IDLE; go to P_WT.
- P_WT: sample u_rdata, then increment the poll count.
  - If bit 5 = 1, go to SEND.
  - Else, if POLL_TIMEOUT≠0 and count==POLL_TIMEOUT, set tx_err, drop the character, and go to IDLE.
  - Else go to P_RD.
- SEND: u_wvalid=1, u_waddr=0, u_wdata=captured char; tx_count+1 (wrapping); go to IDLE.
- Throughput: with POLL_LSR=0, at most one character every 2 cycles.
- u_rvalid and u_wvalid are never high in the same cycle. Both are 0 in IDLE.
- u_waddr/u_wdata/u_raddr are 0 whenever their strobe is low.
- The controller never writes LCR with DLAB=1 outside the init sequence, so every THR write hits THR and never DLL.

Test Plan:
- Reset release with defaults -> cycles 1..6 writes: (3,83),(0,01),(1,00),(3,03),(2,07),(1,00); init_done=1 in cycle 7; no u_rvalid.
- After init, req_valid[0]=1 with data 8'h41 -> req_ready[0] pulse in cycle N; THR write (0,41) in cycle N+1; tx_count=1.
- req_valid=2'b11 held, data0=8'h61, data1=8'h62 -> grant order 0,1,0,1; THR sequence 61,62,61,62; writes 2 cycles apart.
- POLL_LSR=1; u_rdata bit 5 returns 0,0,0 then 1 -> 4 P_RD strobes at raddr 5, then one THR write; tx_err=0.
- POLL_LSR=1, POLL_TIMEOUT=3, THRE stuck at 0 -> exactly 3 polls; no THR write; tx_err=1 and stays 1; next request is still served.
- rstn pulled low during P_WT with a captured char -> all outputs 0; after release, the init sequence repeats from (3,83); the dropped char is never written.

Source files
------------

// File: rtl/uart8250_ctrl.sv
// 8250 register-port front end: programs the UART once after reset, then
// round-robin shares the transmit holding register among NREQ producers.
module uart8250_ctrl #(
  parameter int unsigned NREQ         = 2,
  parameter logic [15:0] DIVISOR      = 16'h0001,
  parameter logic [7:0]  LCR_CFG      = 8'h03,
  parameter logic [7:0]  FCR_CFG      = 8'h07,
  parameter bit          POLL_LSR     = 1'b0,
  parameter int unsigned POLL_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              init_done,
  output logic              busy,
  output logic              tx_err,
  output logic [15:0]       tx_count,
  output logic              u_rvalid,
  output logic [2:0]        u_raddr,
  input  logic [7:0]        u_rdata,
  output logic              u_wvalid,
  output logic [2:0]        u_waddr,
  output logic [7:0]        u_wdata
);

  localparam int unsigned PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 8;

  localparam logic [ADDR_W-1:0] A_THR = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_DLM = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_IER = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_FCR = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_LCR = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_LSR = ADDR_W'(5);

  typedef enum logic [3:0] {
    I_LCRD, I_DLL, I_DLM, I_LCR, I_FCR, I_IER, IDLE, P_RD, P_WT, SEND
  } state_t;

  // The state register names the operation being performed in the coming
  // cycle; every output is registered from the decode of that operation.
  state_t state, state_nxt;
  logic run;
  logic [PTR_W-1:0]  ptr, ptr_nxt;
  logic [DATA_W-1:0] chr, chr_nxt;
  logic [CNT_W-1:0]  polls, polls_nxt;

  logic [NREQ-1:0]   ready_nxt;
  logic              done_nxt, busy_nxt, err_nxt;
  logic [15:0]       count_nxt;
  logic              rvalid_nxt, wvalid_nxt;
  logic [ADDR_W-1:0] raddr_nxt, waddr_nxt;
  logic [DATA_W-1:0] wdata_nxt;

  logic [NREQ-1:0][DATA_W-1:0] data_v;
  logic              found;
  logic [PTR_W-1:0]  gnt;
  logic              unused_rdata;

  assign data_v       = req_data;
  assign unused_rdata = ^{u_rdata[7:6], u_rdata[4:0]};

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    chr_nxt    = chr;
    polls_nxt  = polls;
    ready_nxt  = '0;
    done_nxt   = init_done;
    busy_nxt   = 1'b0;
    err_nxt    = tx_err;
    count_nxt  = tx_count;
    rvalid_nxt = 1'b0;
    raddr_nxt  = '0;
    wvalid_nxt = 1'b0;
    waddr_nxt  = '0;
    wdata_nxt  = '0;
    found      = 1'b0;
    gnt        = '0;

    // The first cycle after reset release performs I_LCRD itself.
    if (run) begin
      case (state)
        I_LCRD:  state_nxt = I_DLL;
        I_DLL:   state_nxt = I_DLM;
        I_DLM:   state_nxt = I_LCR;
        I_LCR:   state_nxt = I_FCR;
        I_FCR:   state_nxt = I_IER;
        I_IER:   state_nxt = IDLE;
        IDLE:    if (|req_ready) state_nxt = POLL_LSR ? P_RD : SEND;
        P_RD:    state_nxt = P_WT;
        P_WT: begin
          polls_nxt = polls + CNT_W'(1);
          if (u_rdata[5]) begin
            state_nxt = SEND;
          end else if (POLL_TIMEOUT != 0 && polls_nxt == CNT_W'(POLL_TIMEOUT)) begin
            err_nxt   = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = P_RD;
          end
        end
        SEND:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end

    busy_nxt = (state_nxt != IDLE);

    case (state_nxt)
      I_LCRD: begin wvalid_nxt = 1'b1; waddr_nxt = A_LCR; wdata_nxt = 8'h80 | LCR_CFG; end
      I_DLL:  begin wvalid_nxt = 1'b1; waddr_nxt = A_THR; wdata_nxt = DIVISOR[7:0]; end
      I_DLM:  begin wvalid_nxt = 1'b1; waddr_nxt = A_DLM; wdata_nxt = DIVISOR[15:8]; end
      I_LCR:  begin wvalid_nxt = 1'b1; waddr_nxt = A_LCR; wdata_nxt = LCR_CFG & 8'h7F; end
      I_FCR:  begin wvalid_nxt = 1'b1; waddr_nxt = A_FCR; wdata_nxt = FCR_CFG; end
      I_IER:  begin wvalid_nxt = 1'b1; waddr_nxt = A_IER; wdata_nxt = 8'h00; end
      IDLE: begin
        done_nxt = 1'b1;
        // Round robin: first valid at or above the pointer, else lowest valid.
        for (int unsigned i = 0; i < NREQ; i++) begin
          if (!found && req_valid[PTR_W'(i)] && PTR_W'(i) >= ptr) begin
            found = 1'b1;
            gnt   = PTR_W'(i);
          end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
          if (!found && req_valid[PTR_W'(i)]) begin
            found = 1'b1;
            gnt   = PTR_W'(i);
          end
        end
        if (found) begin
          ready_nxt[gnt] = 1'b1;
          chr_nxt        = data_v[gnt];
          ptr_nxt        = (32'(gnt) == NREQ - 1) ? '0 : gnt + PTR_W'(1);
          polls_nxt      = '0;
        end
      end
      P_RD: begin rvalid_nxt = 1'b1; raddr_nxt = A_LSR; end
      SEND: begin
        wvalid_nxt = 1'b1;
        waddr_nxt  = A_THR;
        wdata_nxt  = chr;
        count_nxt  = tx_count + 16'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= I_LCRD;
      run       <= 1'b0;
      ptr       <= '0;
      chr       <= '0;
      polls     <= '0;
      req_ready <= '0;
      init_done <= 1'b0;
      busy      <= 1'b0;
      tx_err    <= 1'b0;
      tx_count  <= '0;
      u_rvalid  <= 1'b0;
      u_raddr   <= '0;
      u_wvalid  <= 1'b0;
      u_waddr   <= '0;
      u_wdata   <= '0;
    end else begin
      state     <= state_nxt;
      run       <= 1'b1;
      ptr       <= ptr_nxt;
      chr       <= chr_nxt;
      polls     <= polls_nxt;
      req_ready <= ready_nxt;
      init_done <= done_nxt;
      busy      <= busy_nxt;
      tx_err    <= err_nxt;
      tx_count  <= count_nxt;
      u_rvalid  <= rvalid_nxt;
      u_raddr   <= raddr_nxt;
      u_wvalid  <= wvalid_nxt;
      u_waddr   <= waddr_nxt;
      u_wdata   <= wdata_nxt;
    end
  end

endmodule
